// File: rtl/rr_arb_idx8_pkg.sv
// Shared constants, FSM encoding and rotating-priority helper for round-robin arbiters.
package rr_arb_idx8_pkg;

  localparam int N    = 8;
  localparam int IDXW = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // First set bit of vec, scanning base, base+1, ... modulo N; 0 when vec is empty.
  function automatic logic [IDXW-1:0] rr_first(input logic [N-1:0]    vec,
                                               input logic [IDXW-1:0] base);
    logic [IDXW-1:0] cand;
    logic [IDXW-1:0] win;
    logic            found;
    win   = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      cand = IDXW'(int'(base) + i);
      if (!found && vec[cand]) begin
        win   = cand;
        found = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/rr_pick8.sv
// Combinational rotating-priority picker: lowest index at or after ptr (mod 8) wins.
module rr_pick8
  import rr_arb_idx8_pkg::*;
(
  input  logic [N-1:0]    req,
  input  logic [IDXW-1:0] ptr,
  output logic [IDXW-1:0] winner,
  output logic            any
);

  always_comb begin
    winner = rr_first(req, ptr);
    any    = |req;
  end

endmodule

// File: rtl/rr_arb_idx8.sv
// Round-robin arbiter over 8 requesters; drives a 3-to-8 decoder with registered idx/en.
//
//   state | meaning
//   IDLE  | no grant; arbitrate req from ptr, en=0 (always at least one dead cycle)
//   GRANT | idx owns the bus until it drops req or hits MAX_HOLD cycles
module rr_arb_idx8
  import rr_arb_idx8_pkg::*;
#(
  parameter int MAX_HOLD = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  output logic [IDXW-1:0] idx,
  output logic            en,
  output logic            timeout
);

  localparam int HW = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_LAST = (MAX_HOLD < 1) ? '0 : HW'(MAX_HOLD - 1);

  state_t          state;
  logic [IDXW-1:0] ptr;
  logic [HW-1:0]   hold_cnt;
  logic [IDXW-1:0] winner;
  logic            any;

  rr_pick8 u_pick (
    .req    (req),
    .ptr    (ptr),
    .winner (winner),
    .any    (any)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      hold_cnt <= '0;
      idx      <= '0;
      en       <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (any) begin
            idx      <= winner;
            en       <= 1'b1;
            hold_cnt <= '0;
            state    <= GRANT;
          end
        end
        GRANT: begin
          if (!req[idx]) begin
            en    <= 1'b0;
            ptr   <= idx + 1'b1;
            state <= IDLE;
          end else if ((MAX_HOLD != 0) && (hold_cnt == HOLD_LAST)) begin
            // forced release; ptr still advances so the hog drops to lowest priority
            en      <= 1'b0;
            timeout <= 1'b1;
            ptr     <= idx + 1'b1;
            state   <= IDLE;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: begin
          en    <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arb_idx8.sv
// Directed bench: default-hold arbiter plus a MAX_HOLD=4 instance for the timeout path.
module tb_rr_arb_idx8;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic [7:0] req_to;
  logic [2:0] idx, idx_to;
  logic       en, en_to;
  logic       timeout, timeout_to;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rr_arb_idx8 u_dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .idx     (idx),
    .en      (en),
    .timeout (timeout)
  );

  rr_arb_idx8 #(.MAX_HOLD(4)) u_dut_to (
    .clk     (clk),
    .rst     (rst),
    .req     (req_to),
    .idx     (idx_to),
    .en      (en_to),
    .timeout (timeout_to)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  // drive both request vectors, advance one edge, sample 1ns later
  task automatic step(input logic [7:0] r, input logic [7:0] rt);
    req    = r;
    req_to = rt;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_a(input string tag, input int e_en, input int e_idx, input int e_to);
    chk({tag, ".en"}, int'(en), e_en);
    chk({tag, ".idx"}, int'(idx), e_idx);
    chk({tag, ".timeout"}, int'(timeout), e_to);
  endtask

  task automatic expect_b(input string tag, input int e_en, input int e_idx, input int e_to);
    chk({tag, ".en"}, int'(en_to), e_en);
    chk({tag, ".idx"}, int'(idx_to), e_idx);
    chk({tag, ".timeout"}, int'(timeout_to), e_to);
  endtask

  initial begin
    rst    = 1'b1;
    req    = '0;
    req_to = '0;
    #1;
    step(8'h00, 8'h00);
    step(8'h00, 8'h00);
    expect_a("reset", 0, 0, 0);
    expect_b("reset_to", 0, 0, 0);
    rst = 1'b0;
    step(8'h00, 8'h00);
    expect_a("idle_hold", 0, 0, 0);

    // single requester 2 for 5 cycles; ptr ends at 3
    for (int k = 0; k < 5; k++) begin
      step(8'h04, 8'h00);
      expect_a($sformatf("single%0d", k), 1, 2, 0);
    end
    step(8'h00, 8'h00);
    expect_a("single_rel", 0, 2, 0);
    step(8'h00, 8'h00);
    expect_a("idx_holds", 0, 2, 0);

    // rotation 3 -> 7 -> 0 -> 3, each released by dropping its own bit once
    step(8'h89, 8'h00);  expect_a("rot_g3", 1, 3, 0);
    step(8'h89, 8'h00);  expect_a("rot_g3_hold", 1, 3, 0);
    step(8'h81, 8'h00);  expect_a("rot_dead1", 0, 3, 0);
    step(8'h89, 8'h00);  expect_a("rot_g7", 1, 7, 0);
    step(8'h09, 8'h00);  expect_a("rot_dead2", 0, 7, 0);
    step(8'h89, 8'h00);  expect_a("rot_wrap_g0", 1, 0, 0);
    step(8'h88, 8'h00);  expect_a("rot_dead3", 0, 0, 0);
    step(8'h89, 8'h00);  expect_a("rot_g3b", 1, 3, 0);
    step(8'h81, 8'h00);  expect_a("rot_dead4", 0, 3, 0);
    step(8'h00, 8'h00);  expect_a("rot_idle", 0, 3, 0);

    // timeout at MAX_HOLD=4 on the second instance
    for (int k = 0; k < 4; k++) begin
      step(8'h00, 8'h20);
      expect_b($sformatf("to_hold%0d", k), 1, 5, 0);
    end
    step(8'h00, 8'h20);  expect_b("to_fire", 0, 5, 1);
    step(8'h00, 8'h20);  expect_b("to_regrant", 1, 5, 0);
    step(8'h00, 8'h00);  expect_b("to_release", 0, 5, 0);
    step(8'h00, 8'h00);  expect_b("to_quiet", 0, 5, 0);

    // default MAX_HOLD=15 boundary on the first instance
    for (int k = 0; k < 15; k++) begin
      step(8'h02, 8'h00);
      chk($sformatf("hold15_en%0d", k), int'(en), 1);
      chk($sformatf("hold15_to%0d", k), int'(timeout), 0);
    end
    step(8'h02, 8'h00);  expect_a("hold15_fire", 0, 1, 1);
    step(8'h00, 8'h00);  expect_a("hold15_quiet", 0, 1, 0);

    // reset mid-grant
    step(8'h40, 8'h00);  expect_a("mid_g6", 1, 6, 0);
    rst = 1'b1;
    step(8'h40, 8'h00);  expect_a("mid_rst", 0, 0, 0);
    rst = 1'b0;
    step(8'h40, 8'h00);  expect_a("post_rst_g6", 1, 6, 0);
    step(8'h00, 8'h00);  expect_a("post_rst_rel", 0, 6, 0);
    // ptr is now 7; reset must return it to 0 so requester 0 beats 7
    rst = 1'b1;
    step(8'h00, 8'h00);
    rst = 1'b0;
    step(8'h81, 8'h00);  expect_a("ptr_reset", 1, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
